load_store_unit: RTL
====================

// Module: load_store_unit
// PURPOSE
//  Multi-cycle data-memory access stage for the RISC-V core. Executes LB/LH/LW/LBU/LHU/SB/SH/SW
//  over a req/ack memory port and returns the aligned, extended load result.
//  load_data drives the writeback select's non-U/J "mux" input.
//  It sits directly upstream of the writeback select.
// PARAMETERS
//  TIMEOUT_CYCLES  255  max cycles in REQ without mem_ack before abort with err (1..255)
// PORTS
//  clk         in   1   system clock, rising edge
//  rst         in   1   asynchronous, active-high reset
//  start       in   1   launch access; sampled only in IDLE
//  opcode      in   5   instr[6:2]; `OPCODE_LOAD or `OPCODE_STORE, else ignored
//  funct3      in   3   width/sign select (000 B, 001 H, 010 W, 100 BU, 101 HU)
//  addr        in   32  byte address (rs1+imm)
//  store_data  in   32  rs2 value
//  busy        out  1   high in any state other than IDLE
//  done        out  1   one-cycle completion pulse
//  err         out  1   valid with done: timeout or illegal funct3
//  misalign    out  1   valid with done: misaligned access (see CONFIGURATION)
//  load_data   out  32  extended load result; held until the next load completes
//  mem_req     out  1   memory request, held until mem_ack
//  mem_we      out  1   1 = store
//  mem_addr    out  32  word-aligned address ({addr[31:2],2'b00})
//  mem_be      out  4   byte enables
//  mem_wdata   out  32  lane-replicated store data
//  mem_rdata   in   32  read word, valid with mem_ack
//  mem_ack     in   1   single-cycle acknowledge
// BEHAVIOUR
//  - Reset (async): state IDLE; all outputs 0, including load_data and mem_*.
//    An in-flight request is dropped immediately.
//  - FSM IDLE -> REQ -> DONE -> IDLE (Moore outputs).
//    - IDLE: on start with a load/store opcode, latch opcode/funct3/addr/store_data,
//      clear the timer, and go to REQ. Any other opcode: no action.
//    - REQ: mem_req=1, with mem_we/addr/be/wdata from the latched values, stable while waiting.
//      mem_ack in any REQ cycle (including the first) -> DONE; a load captures the extended
//      mem_rdata into load_data. Timer reaching TIMEOUT_CYCLES with no ack -> DONE, err=1,
//      load_data unchanged.
//    - DONE: done=1 for exactly one cycle, then IDLE.
//  - Illegal funct3 (011, 110, 111; for stores also 1xx): IDLE -> DONE directly, err=1, no mem_req.
//  - start while busy is ignored. Minimum latency start -> done is 2 cycles (ack in first REQ cycle).
//  - Byte lanes, with o=addr[1:0]:
//    - B: be=4'b0001<<o, wdata={4{sd[7:0]}}.
//    - H: be=4'b0011<<{o[1],1'b0}, wdata={2{sd[15:0]}}.
//    - W: be=4'b1111, wdata=sd.
//  - Load extract: byte rdata[8*o+:8], half rdata[16*o[1]+:16].
//    Sign-extend for B/H; zero-extend for BU/HU.
//  - Loads drive mem_be per width as well (informational).
//  - mem_ack outside REQ is ignored.
// CONFIGURATION
//  MISALIGN_TRAP_EN defined: H with addr[0]=1, or W with addr[1:0]!=0 -> IDLE -> DONE with
//    misalign=1 and no memory access.
//  MISALIGN_TRAP_EN undefined: misalign tied 0; offending low address bits are ignored
//    (H uses o[1] only, W uses lane 0).
// STRUCTURE
//  defines.v: `OPCODE_LOAD, `OPCODE_STORE, funct3 codes (`F3_LB..`F3_SW), FSM state encodings.
//  Sub-module lsu_align: combinational byte-enable/wdata generation and load extract/extension.
//  The FSM and timer stay in the top level.
// TESTING
//  1. LW addr=0x100, ack on 1st REQ cycle, rdata=0xDEADBEEF:
//     -> mem_addr=0x100, be=1111; done on cycle 2; load_data=0xDEADBEEF.
//  2. LB addr=0x103, rdata=0x80FF_0000 -> be=1000, load_data=0xFFFFFF80.
//     LBU at the same address -> 0x00000080.
//  3. SH addr=0x22, sd=0x1234ABCD -> mem_we=1, be=1100, wdata=0xABCDABCD, addr=0x20; err=0.
//  4. Ack withheld, TIMEOUT_CYCLES=4 -> mem_req high 4 cycles, then done=1 with err=1;
//     load_data holds its prior value.
//  5. LW addr=0x101: with MISALIGN_TRAP_EN -> no mem_req, done with misalign=1;
//     without it -> access to 0x100, be=1111.
//  6. rst asserted mid-REQ -> mem_req/busy/done low immediately; a new start after release
//     completes normally. start pulses while busy and funct3=011 (err, no req) are also covered.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: opcodes, funct3 codes,
// FSM state type and small decode helpers.
package load_store_unit_pkg;

  localparam logic [4:0] OPCODE_LOAD  = 5'b00000;
  localparam logic [4:0] OPCODE_STORE = 5'b01000;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } lsu_state_t;

  // Stores only accept B/H/W; loads additionally accept BU/HU.
  function automatic logic f3_illegal(input logic is_store, input logic [2:0] f3);
    case (f3)
      F3_LB, F3_LH, F3_LW: f3_illegal = 1'b0;
      F3_LBU, F3_LHU:      f3_illegal = is_store;
      default:             f3_illegal = 1'b1;
    endcase
  endfunction

  // Halfword needs an even address, word needs a 4-byte aligned address.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] ofs);
    case (f3[1:0])
      2'b01:   is_misaligned = ofs[0];
      2'b10:   is_misaligned = (ofs != 2'b00);
      default: is_misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// lsu_align: combinational lane steering. Builds byte enables and the
// lane-replicated store word, and extracts/extends the load result.
module lsu_align
  import load_store_unit_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_value
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  assign byte_v = rdata[{offset, 3'b000} +: 8];
  assign half_v = rdata[{offset[1], 4'b0000} +: 16];

  // Width decode: enables, replicated write data and extended read data.
  always_comb begin
    be         = 4'b1111;
    wdata      = store_data;
    load_value = rdata;
    case (funct3[1:0])
      2'b00: begin
        be         = 4'b0001 << offset;
        wdata      = {4{store_data[7:0]}};
        load_value = funct3[2] ? {24'b0, byte_v} : {{24{byte_v[7]}}, byte_v};
      end
      2'b01: begin
        be         = 4'b0011 << {offset[1], 1'b0};
        wdata      = {2{store_data[15:0]}};
        load_value = funct3[2] ? {16'b0, half_v} : {{16{half_v[15]}}, half_v};
      end
      default: begin
        be         = 4'b1111;
        wdata      = store_data;
        load_value = rdata;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: multi-cycle data-memory access stage over a req/ack port.
// Optional macro MISALIGN_TRAP_EN: misaligned H/W accesses complete at once
// with misalign=1 instead of silently ignoring the low address bits.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [4:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        misalign,
  output logic [31:0] load_data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT_CYCLES - 1);

  lsu_state_t  state, next_state;
  logic        store_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q;
  logic [31:0] sd_q;
  logic [7:0]  timer;
  logic        err_q;
  logic        mis_q;

  logic        is_store_in;
  logic        launch;
  logic        illegal_in;
  logic        mis_in;
  logic        timeout_hit;
  logic [3:0]  be_w;
  logic [31:0] wdata_w;
  logic [31:0] load_value;

  assign is_store_in = (opcode == OPCODE_STORE);
  assign launch      = start && ((opcode == OPCODE_LOAD) || is_store_in);
  assign illegal_in  = f3_illegal(is_store_in, funct3);
`ifdef MISALIGN_TRAP_EN
  assign mis_in      = is_misaligned(funct3, addr[1:0]);
`else
  assign mis_in      = 1'b0;
`endif
  assign timeout_hit = (timer == TIMER_LAST);

  lsu_align u_align (
    .funct3     (f3_q),
    .offset     (addr_q[1:0]),
    .store_data (sd_q),
    .rdata      (mem_rdata),
    .be         (be_w),
    .wdata      (wdata_w),
    .load_value (load_value)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  // Next-state: traps skip the memory phase; ack wins over a same-cycle timeout.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (launch) next_state = (illegal_in || mis_in) ? ST_DONE : ST_REQ;
      ST_REQ:  if (mem_ack || timeout_hit) next_state = ST_DONE;
      default: next_state = ST_IDLE;
    endcase
  end

  // Moore outputs; memory port is zero outside REQ.
  always_comb begin
    busy      = (state != ST_IDLE);
    done      = (state == ST_DONE);
    err       = done && err_q;
    misalign  = done && mis_q;
    mem_req   = (state == ST_REQ);
    mem_we    = mem_req && store_q;
    mem_addr  = mem_req ? {addr_q[31:2], 2'b00} : '0;
    mem_be    = mem_req ? be_w : '0;
    mem_wdata = mem_req ? wdata_w : '0;
  end

  // Access latch, wait timer, status flags and load result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      store_q   <= 1'b0;
      f3_q      <= '0;
      addr_q    <= '0;
      sd_q      <= '0;
      timer     <= '0;
      err_q     <= 1'b0;
      mis_q     <= 1'b0;
      load_data <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (launch) begin
            store_q <= is_store_in;
            f3_q    <= funct3;
            addr_q  <= addr;
            sd_q    <= store_data;
            timer   <= '0;
            err_q   <= illegal_in;
            mis_q   <= mis_in && !illegal_in;
          end
        end
        ST_REQ: begin
          if (mem_ack) begin
            if (!store_q) load_data <= load_value;
          end else if (timeout_hit) begin
            err_q <= 1'b1;
          end else begin
            timer <= timer + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
